// File: rtl/iter_div.sv
// iter_div: iterative restoring divider for DIV/DIVU.
// One shift-subtract step per cycle on operand magnitudes, then a single
// finishing cycle that applies signs and the divide-by-zero convention.
module iter_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    step;
    logic [WIDTH-1:0] q_work;    // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] r_work;    // partial remainder, always < d_mag
    logic [WIDTH-1:0] d_mag;     // divisor magnitude
    logic [WIDTH-1:0] a_orig;    // raw dividend, returned as remainder on divide-by-zero
    logic             neg_q;
    logic             neg_r;
    logic             zero_div;

    logic [WIDTH-1:0] a_mag_in;
    logic [WIDTH-1:0] b_mag_in;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_diff;
    logic             fits;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    // Operand magnitudes; held as unsigned WIDTH-bit values so the most
    // negative input maps to 2^(WIDTH-1) without wrapping.
    always_comb begin
        a_mag_in = dividend;
        b_mag_in = divisor;
        if (is_signed && dividend[WIDTH-1]) begin
            a_mag_in = -dividend;
        end
        if (is_signed && divisor[WIDTH-1]) begin
            b_mag_in = -divisor;
        end
    end

    // One restoring step: shift in next dividend bit, subtract if it fits.
    always_comb begin
        r_shift = {r_work, q_work[WIDTH-1]};
        r_diff  = r_shift - {1'b0, d_mag};
        fits    = (r_shift >= {1'b0, d_mag});
        r_next  = fits ? r_diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
        q_next  = {q_work[WIDTH-2:0], fits};
    end

    // Final sign correction and divide-by-zero override.
    always_comb begin
        q_fin = neg_q ? -q_work : q_work;
        r_fin = neg_r ? -r_work : r_work;
        if (zero_div) begin
            q_fin = '1;
            r_fin = a_orig;
        end
    end

    // Control FSM with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            q_work    <= '0;
            r_work    <= '0;
            d_mag     <= '0;
            a_orig    <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            zero_div  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        step     <= '0;
                        q_work   <= a_mag_in;
                        r_work   <= '0;
                        d_mag    <= b_mag_in;
                        a_orig   <= dividend;
                        neg_q    <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r    <= is_signed & dividend[WIDTH-1];
                        zero_div <= (divisor == '0);
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (step == CW'(WIDTH)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_fin;
                        remainder <= r_fin;
                        div_zero  <= zero_div;
                    end else begin
                        step   <= step + CW'(1);
                        q_work <= q_next;
                        r_work <= r_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
